// File: rtl/vram_text_blitter_pkg.sv
// ============================================================================
// Module  : vram_text_blitter_pkg
// Purpose : Shared constants, op encodings and FSM state type for the blitter.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package vram_text_blitter_pkg;

    localparam int COLS        = 80;
    localparam int ROWS        = 60;
    localparam int FRAME_BYTES = 38400;
    localparam int LINE_STRIDE = 80;

    localparam logic OP_GLYPH = 1'b0;
    localparam logic OP_FILL  = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } blit_state_t;

endpackage

`default_nettype wire

// File: rtl/vram_text_blitter_font.sv
// ============================================================================
// Module  : hex_font_rom
// Purpose : Combinational 8x8 hex digit font, LSB is the leftmost pixel.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module hex_font_rom (
    input  logic [3:0] char,
    input  logic [2:0] line,
    output logic [7:0] row
);

    logic [63:0] w_bits;
    logic [63:0] w_shifted;

    // Line 0 sits in the top byte; the bottom byte is the blank spacer line.
    always_comb begin
        w_bits = 64'h0;
        case (char)
            4'h0: w_bits = 64'h7c868a92a2c27c00;
            4'h1: w_bits = 64'h101814101010_7c00;
            4'h2: w_bits = 64'h3c4240300c027e00;
            4'h3: w_bits = 64'h3c42403840423c00;
            4'h4: w_bits = 64'h203028247e202000;
            4'h5: w_bits = 64'h7e023e4040423c00;
            4'h6: w_bits = 64'h3804023e42423c00;
            4'h7: w_bits = 64'h7e40201008080800;
            4'h8: w_bits = 64'h3c42423c42423c00;
            4'h9: w_bits = 64'h3c42427c40201c00;
            4'hA: w_bits = 64'h182442427e424200;
            4'hB: w_bits = 64'h3e42423e42423e00;
            4'hC: w_bits = 64'h3c42020202423c00;
            4'hD: w_bits = 64'h1e22424242221e00;
            4'hE: w_bits = 64'h7e02023e02027e00;
            4'hF: w_bits = 64'h7e02023e02020200;
            default: w_bits = 64'h0;
        endcase
    end

    assign w_shifted = w_bits << {line, 3'b000};
    assign row       = w_shifted[63:56];

endmodule

`default_nettype wire

// File: rtl/vram_text_blitter.sv
// ============================================================================
// Module  : vram_text_blitter
// Purpose : Draws hex glyphs or fills the 1bpp frame via VRAM port A req/gnt.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module vram_text_blitter #(
    parameter int COLS        = vram_text_blitter_pkg::COLS,
    parameter int ROWS        = vram_text_blitter_pkg::ROWS,
    parameter int FRAME_BYTES = vram_text_blitter_pkg::FRAME_BYTES,
    parameter int ADDR_W      = 16
) (
    input  logic              mclk,
    input  logic              resetn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [3:0]        cmd_char,
    input  logic [6:0]        cmd_col,
    input  logic [5:0]        cmd_row,
    input  logic              cmd_inv,
    input  logic [7:0]        cmd_fill,
    output logic              vram_req,
    input  logic              vram_gnt,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [7:0]        vram_din,
    output logic              busy,
    output logic              done,
    output logic              err
);

    import vram_text_blitter_pkg::*;

    localparam logic [6:0]        c_max_col   = 7'(COLS);
    localparam logic [5:0]        c_max_row   = 6'(ROWS);
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] c_stride    = ADDR_W'(LINE_STRIDE);

    blit_state_t       r_state;
    logic              r_ready;
    logic              r_req;
    logic              r_busy;
    logic              r_done;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_din;
    logic              r_op;
    logic [3:0]        r_char;
    logic              r_inv;
    logic [7:0]        r_fill;
    logic [2:0]        r_line;

    logic              w_idle;
    logic [3:0]        w_rom_char;
    logic [2:0]        w_rom_line;
    logic [7:0]        w_rom_row;
    logic [ADDR_W-1:0] w_row_ext;
    logic [ADDR_W-1:0] w_base;
    logic              w_bad_cell;
    logic              w_last;

    assign w_idle = (r_state == S_IDLE);

    // In IDLE the ROM looks up line 0 of the incoming command so the first
    // byte is ready in REQ; afterwards it pre-fetches the next line.
    assign w_rom_char = w_idle ? cmd_char : r_char;
    assign w_rom_line = w_idle ? 3'd0 : r_line + 3'd1;

    hex_font_rom u_font (
        .char (w_rom_char),
        .line (w_rom_line),
        .row  (w_rom_row)
    );

    // row*640 + col without a multiplier
    assign w_row_ext  = ADDR_W'(cmd_row);
    assign w_base     = (w_row_ext << 9) + (w_row_ext << 7) + ADDR_W'(cmd_col);
    assign w_bad_cell = (cmd_col >= c_max_col) || (cmd_row >= c_max_row);
    assign w_last     = (r_op == OP_FILL) ? (r_addr == c_last_addr) : (r_line == 3'd7);

    always_ff @(posedge mclk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
            r_ready <= 1'b1;
            r_req   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_din   <= '0;
            r_op    <= OP_GLYPH;
            r_char  <= '0;
            r_inv   <= 1'b0;
            r_fill  <= '0;
            r_line  <= '0;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_op   <= cmd_op;
                        r_char <= cmd_char;
                        r_inv  <= cmd_inv;
                        r_fill <= cmd_fill;
                        r_line <= 3'd0;
                        if (cmd_op == OP_GLYPH && w_bad_cell) begin
                            r_err <= 1'b1;
                        end else begin
                            r_state <= S_REQ;
                            r_ready <= 1'b0;
                            r_req   <= 1'b1;
                            r_busy  <= 1'b1;
                            if (cmd_op == OP_FILL) begin
                                r_addr <= '0;
                                r_din  <= cmd_fill;
                            end else begin
                                r_addr <= w_base;
                                r_din  <= w_rom_row ^ {8{cmd_inv}};
                            end
                        end
                    end
                end
                S_REQ, S_WRITE: begin
                    // Without a grant nothing moves: address and data hold.
                    if (vram_gnt) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                            r_req   <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_WRITE;
                            r_line  <= r_line + 3'd1;
                            if (r_op == OP_FILL) begin
                                r_addr <= r_addr + ADDR_W'(1);
                                r_din  <= r_fill;
                            end else begin
                                r_addr <= r_addr + c_stride;
                                r_din  <= w_rom_row ^ {8{r_inv}};
                            end
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                    r_req   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign vram_req  = r_req;
    assign vram_we   = r_req & vram_gnt;
    assign vram_addr = r_addr;
    assign vram_din  = r_din;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_vram_text_blitter.sv
// ============================================================================
// Module  : tb_vram_text_blitter
// Purpose : Self-checking bench: vector table of draw commands plus sequences.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vram_text_blitter;

    logic        mclk = 1'b0;
    logic        resetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [3:0]  cmd_char = '0;
    logic [6:0]  cmd_col = '0;
    logic [5:0]  cmd_row = '0;
    logic        cmd_inv = 1'b0;
    logic [7:0]  cmd_fill = '0;
    logic        vram_req;
    logic        vram_gnt = 1'b0;
    logic        vram_we;
    logic [15:0] vram_addr;
    logic [7:0]  vram_din;
    logic        busy;
    logic        done;
    logic        err;

    vram_text_blitter dut (
        .mclk      (mclk),
        .resetn    (resetn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_char  (cmd_char),
        .cmd_col   (cmd_col),
        .cmd_row   (cmd_row),
        .cmd_inv   (cmd_inv),
        .cmd_fill  (cmd_fill),
        .vram_req  (vram_req),
        .vram_gnt  (vram_gnt),
        .vram_we   (vram_we),
        .vram_addr (vram_addr),
        .vram_din  (vram_din),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 mclk = ~mclk;

    int checks = 0;
    int errors = 0;

    // Observation state, sampled on the falling edge.
    int          cyc = 0;
    int          acc_cyc = -1;
    int          first_cyc = -1;
    int          last_cyc = -1;
    int          done_cyc = -1;
    int          err_cyc = -1;
    int          done_cnt = 0;
    int          err_cnt = 0;
    int          req_seen = 0;
    int          bad_we = 0;
    int          both_cnt = 0;
    logic [15:0] wa[$];
    logic [7:0]  wd[$];
    int          gnt_mode = 0;

    always @(negedge mclk) begin
        cyc = cyc + 1;
        if (cmd_valid && cmd_ready) acc_cyc = cyc;
        if (vram_we) begin
            if (wa.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            wa.push_back(vram_addr);
            wd.push_back(vram_din);
            if (!vram_gnt) bad_we = bad_we + 1;
        end
        if (vram_req) req_seen = req_seen + 1;
        if (done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (err) begin err_cnt = err_cnt + 1; err_cyc = cyc; end
        if (done && err) both_cnt = both_cnt + 1;
    end

    always @(posedge mclk) begin
        #1;
        if (gnt_mode == 1) vram_gnt = ~vram_gnt;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clear_obs();
        wa.delete();
        wd.delete();
        done_cnt = 0; err_cnt = 0; req_seen = 0; bad_we = 0;
        acc_cyc = -1; first_cyc = -1; last_cyc = -1; done_cyc = -1; err_cyc = -1;
    endtask

    task automatic issue(input logic op, input logic [3:0] ch, input logic [6:0] col,
                         input logic [5:0] row, input logic inv, input logic [7:0] fill);
        @(posedge mclk); #1;
        cmd_valid = 1'b1; cmd_op = op; cmd_char = ch; cmd_col = col;
        cmd_row = row; cmd_inv = inv; cmd_fill = fill;
        @(posedge mclk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_end(input string tag, input int max_cyc);
        int n = 0;
        while (done_cnt == 0 && err_cnt == 0 && n < max_cyc) begin
            @(posedge mclk); #1;
            n++;
        end
        chk({tag, " finished in budget"}, (n < max_cyc) ? 1 : 0, 1);
        repeat (4) @(posedge mclk);
        #1;
    endtask

    task automatic check_glyph(input string tag, input logic [15:0] base, input logic [63:0] rows);
        chk({tag, " writes"}, wa.size(), 8);
        for (int k = 0; k < 8; k++) begin
            if (k < wa.size()) begin
                chk($sformatf("%s addr%0d", tag, k), wa[k], base + 16'(k * 80));
                chk($sformatf("%s data%0d", tag, k), wd[k], rows[63 - 8 * k -: 8]);
            end
        end
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " err pulses"}, err_cnt, 0);
        chk({tag, " we without gnt"}, bad_we, 0);
        chk({tag, " ready after"}, cmd_ready, 1);
    endtask

    typedef struct {
        logic        op;
        logic [3:0]  ch;
        logic [6:0]  col;
        logic [5:0]  row;
        logic        inv;
        logic [7:0]  fill;
        logic        exp_err;
        logic [15:0] exp_base;
        logic [63:0] exp_rows;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int bad_a;
        int bad_d;
        int n;

        tbl[0] = '{1'b0, 4'h0, 7'd40, 6'd35, 1'b0, 8'h00, 1'b0, 16'd22440, 64'h7c868a92a2c27c00};
        tbl[1] = '{1'b0, 4'hA, 7'd79, 6'd59, 1'b1, 8'h00, 1'b0, 16'd37839, 64'he7dbbdbd81bdbdff};
        tbl[2] = '{1'b0, 4'h3, 7'd80, 6'd10, 1'b0, 8'h00, 1'b1, 16'd0,     64'h0};
        tbl[3] = '{1'b0, 4'h3, 7'd10, 6'd60, 1'b0, 8'h00, 1'b1, 16'd0,     64'h0};
        tbl[4] = '{1'b0, 4'h1, 7'd0,  6'd0,  1'b0, 8'h00, 1'b0, 16'd0,     64'h1018141010107c00};
        tbl[5] = '{1'b0, 4'hF, 7'd5,  6'd1,  1'b0, 8'h00, 1'b0, 16'd645,   64'h7e02023e02020200};

        // Reset values
        repeat (3) @(posedge mclk);
        #1;
        chk("reset cmd_ready", cmd_ready, 1);
        chk("reset req", vram_req, 0);
        chk("reset we", vram_we, 0);
        chk("reset busy", busy, 0);
        chk("reset done/err", {done, err}, 0);
        chk("reset addr", vram_addr, 0);
        chk("reset din", vram_din, 0);
        resetn = 1'b1;
        vram_gnt = 1'b1;

        for (int i = 0; i < 6; i++) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            clear_obs();
            issue(tbl[i].op, tbl[i].ch, tbl[i].col, tbl[i].row, tbl[i].inv, tbl[i].fill);
            wait_end(tag, 40);
            if (tbl[i].exp_err) begin
                chk({tag, " err pulses"}, err_cnt, 1);
                chk({tag, " err latency"}, err_cyc - acc_cyc, 1);
                chk({tag, " req cycles"}, req_seen, 0);
                chk({tag, " writes"}, wa.size(), 0);
                chk({tag, " done pulses"}, done_cnt, 0);
                chk({tag, " ready"}, cmd_ready, 1);
            end else begin
                check_glyph(tag, tbl[i].exp_base, tbl[i].exp_rows);
                chk({tag, " first write latency"}, first_cyc - acc_cyc, 1);
                chk({tag, " done after last write"}, done_cyc - last_cyc, 1);
            end
        end

        // Grant withheld for 20 cycles; a second command meanwhile is ignored.
        clear_obs();
        vram_gnt = 1'b0;
        issue(1'b0, 4'h2, 7'd10, 6'd2, 1'b0, 8'h00);
        for (int c = 0; c < 19; c++) begin
            if (c == 3) begin
                cmd_valid = 1'b1; cmd_op = 1'b1; cmd_fill = 8'h55;
            end
            if (c == 5) cmd_valid = 1'b0;
            @(posedge mclk); #1;
        end
        chk("stall writes", wa.size(), 0);
        chk("stall req held", vram_req, 1);
        chk("stall busy", busy, 1);
        chk("stall ready", cmd_ready, 0);
        vram_gnt = 1'b1;
        wait_end("stall", 40);
        check_glyph("stall", 16'd1290, 64'h3c4240300c027e00);
        repeat (6) @(posedge mclk);
        #1;
        chk("ignored cmd no extra writes", wa.size(), 8);
        chk("ignored cmd no req", vram_req, 0);

        // Reset in the middle of a glyph
        clear_obs();
        issue(1'b0, 4'h8, 7'd20, 6'd20, 1'b0, 8'h00);
        n = 0;
        while (wa.size() < 3 && n < 50) begin
            @(posedge mclk); #1;
            n++;
        end
        chk("mid-reset reached 3rd write", wa.size(), 3);
        resetn = 1'b0;
        #1;
        chk("async reset req", vram_req, 0);
        chk("async reset we", vram_we, 0);
        chk("async reset busy", busy, 0);
        chk("async reset addr", vram_addr, 0);
        chk("async reset din", vram_din, 0);
        chk("async reset ready", cmd_ready, 1);
        repeat (2) @(posedge mclk);
        #2;
        resetn = 1'b1;
        repeat (10) @(posedge mclk);
        #1;
        chk("mid-reset no further writes", wa.size(), 3);
        chk("mid-reset no done", done_cnt, 0);
        chk("mid-reset ready after release", cmd_ready, 1);

        // Fill with a toggling grant
        clear_obs();
        gnt_mode = 1;
        issue(1'b1, 4'h0, 7'd0, 6'd0, 1'b0, 8'hff);
        wait_end("fill", 80000);
        gnt_mode = 0;
        chk("fill writes", wa.size(), 38400);
        bad_a = 0;
        bad_d = 0;
        for (int i = 0; i < wa.size(); i++) begin
            if (wa[i] !== 16'(i)) bad_a++;
            if (wd[i] !== 8'hff) bad_d++;
        end
        chk("fill addr sequence errors", bad_a, 0);
        chk("fill data errors", bad_d, 0);
        chk("fill we without gnt", bad_we, 0);
        chk("fill done pulses", done_cnt, 1);
        chk("fill last addr", (wa.size() > 0) ? int'(wa[wa.size() - 1]) : -1, 38399);

        chk("done and err together", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/vram_text_blitter.md
Name: vram_text_blitter

Overview:
- Hardware writer for the 1bpp VGA frame buffer: the producer side of the VRAM port whose far end is the VGA scan-out.
- Accepts commands to draw one 8x8 hex glyph (0-F) at a text cell, or to fill the whole frame with a byte.
- Issues the resulting byte writes on VRAM port A, arbitrated against the CPU bus by a req/gnt handshake.
- Offloads character drawing (score, debug digits) from the multi-cycle CPU.

Parameters:
- COLS, 80, text columns (= bytes per scan line, 640/8)
- ROWS, 60, text rows (480/8)
- FRAME_BYTES, 38400, bytes in one 640x480 1bpp frame
- ADDR_W, 16, VRAM byte address width

Ports:
- mclk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  1  0 = draw glyph, 1 = fill frame
- cmd_char  in  4  hex digit to draw
- cmd_col  in  7  text column, 0..COLS-1
- cmd_row  in  6  text row, 0..ROWS-1
- cmd_inv  in  1  invert glyph bytes
- cmd_fill  in  8  fill byte for op 1
- vram_req  out  1  request for VRAM port A
- vram_gnt  in  1  arbiter grant
- vram_we  out  1  write strobe
- vram_addr  out  ADDR_W  byte address
- vram_din  out  8  write data
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: command rejected as out of range

Behaviour:
- Reset (async, resetn=0):
  - state IDLE.
  - cmd_ready=1.
  - vram_req, vram_we, busy, done and err are 0.
  - vram_addr and vram_din are 0.
  - A reset asserted mid-command aborts it immediately, with no further writes.
- Pixel mapping: byte address = y*80 + x/8. Bit i of a byte is pixel x%8 == i, so the LSB is the leftmost pixel.
- States:
  - IDLE:
    - cmd_ready=1.
    - valid&ready latches all cmd fields.
    - Op 0 with col>=COLS or row>=ROWS: pulse err the next cycle, stay IDLE, no request.
    - Any other accepted command goes to REQ.
  - REQ:
    - busy=1, cmd_ready=0, vram_req=1.
    - Moves to WRITE when vram_gnt=1; that same cycle is the first write.
  - WRITE:
    - vram_req stays 1.
    - vram_we = vram_gnt (combinational gating).
    - The address/data counter advances only on cycles with gnt=1.
    - Grant dropped mid-command: stall, hold addr/din, resume when gnt returns.
  - DONE:
    - One cycle.
    - vram_req=0, done=1.
    - Then IDLE with cmd_ready=1.
- Glyph op:
  - base = row*640 + col, computed with shifts/adds (row*512 + row*128 + col).
  - Line k (0..7) writes addr base + k*80 and data font[char][k] XOR {8{inv}}.
  - Exactly 8 writes.
- Fill op:
  - addr 0..FRAME_BYTES-1 ascending, data cmd_fill.
  - Exactly 38400 writes.
  - The counter stops at 38399 and never wraps.
- Latency with continuous grant: accept at cycle 0, req at cycle 1, writes at cycles 1-8 (glyph) or 1-38400 (fill), done pulse in the following cycle.
- cmd_valid while busy is ignored; nothing is queued.
- done and err are never asserted in the same cycle.

Decomposition:
- Shared package holds the constants COLS, ROWS, FRAME_BYTES, LINE_STRIDE=80 and the op encodings OP_GLYPH=0, OP_FILL=1.
- One sub-module, hex_font_rom: combinational, inputs char[3:0] and line[2:0], output 8-bit row.
  - Glyph 0 rows are 7c 86 8a 92 a2 c2 7c 00.
  - Line 7 is 00 for every glyph.

Test Plan:
- Glyph '0' at col 40, row 35, gnt tied 1 -> addrs 22440, 22520 ... 23000, data 7c 86 8a 92 a2 c2 7c 00, 8 we pulses, done one cycle after the last write.
- Glyph 'A' at col 79, row 59, inv=1 -> first addr 37839, last addr 38399, data = ~font rows; no address beyond 38399.
- Glyph at col 80 or row 60 -> err pulse one cycle after accept, no vram_req, cmd_ready stays 1.
- Fill 0xFF with gnt toggling every other cycle -> exactly 38400 we pulses, addrs 0..38399 contiguous, we never high while gnt=0, done once.
- Glyph drawn while gnt held low for 20 cycles after req -> req held, zero writes, then 8 correct writes; a second cmd_valid during the command is ignored.
- resetn pulsed low after the 3rd write of a glyph -> outputs return to reset values asynchronously, no further writes, cmd_ready=1 after release.
